// File: rtl/mul_pkg.sv
// Shared definitions for the multiply issue/retire sequencer.
package mul_pkg;

  // Number of run cycles the iterative multiplier needs per product.
  localparam int ITER = 32;

  // Architectural word width.
  localparam int WORD_W = 32;

  // Sequencer states. DONE_PEND holds a finished product while a second
  // request is already captured in the operand register.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    DONE      = 2'd2,
    DONE_PEND = 2'd3
  } mul_state_t;

endpackage

// File: rtl/mul_sequencer.sv
// Issue/retire sequencer in front of the iterative multiplier. It accepts
// requests, holds the operands on the multiplier for a whole run, captures
// the 64-bit product when the multiplier drops stall, presents it on the
// response channel, and keeps the architectural H register.
module mul_sequencer
  import mul_pkg::*;
(
  input  logic              CLK,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [WORD_W-1:0] req_x,
  input  logic [WORD_W-1:0] req_y,
  input  logic              req_u,
  output logic              mul_run,
  output logic              mul_u,
  output logic [WORD_W-1:0] mul_x,
  output logic [WORD_W-1:0] mul_y,
  input  logic              mul_stall,
  input  logic [63:0]       mul_z,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_lo,
  output logic [WORD_W-1:0] rsp_hi,
  output logic [WORD_W-1:0] h_reg
);

  mul_state_t        state_reg;

  // Operand register, presented unchanged to the multiplier.
  logic [WORD_W-1:0] op_x_reg;
  logic [WORD_W-1:0] op_y_reg;
  logic              op_u_reg;
  logic              pend_reg;

  // Result register and its occupancy flag.
  logic [WORD_W-1:0] res_lo_reg;
  logic [WORD_W-1:0] res_hi_reg;
  logic              full_reg;

  // Registered handshake/control outputs.
  logic              ready_reg;
  logic              run_reg;
  logic [WORD_W-1:0] h_word_reg;

  logic              accept;
  logic              capture;

  assign accept  = req_valid & ready_reg;
  // The multiplier is only listened to while a run is actually in progress.
  assign capture = (state_reg == RUN) & ~mul_stall;

  assign req_ready = ready_reg;
  assign mul_run   = run_reg;
  assign mul_u     = op_u_reg;
  assign mul_x     = op_x_reg;
  assign mul_y     = op_y_reg;
  assign rsp_valid = full_reg;
  assign rsp_lo    = res_lo_reg;
  assign rsp_hi    = res_hi_reg;
  assign h_reg     = h_word_reg;

  // Sequencer FSM: operand/result registers, run control and handshakes.
  // Every transition into RUN leaves from IDLE, DONE or DONE_PEND, all of
  // which drive run low, so the multiplier always sees at least one idle
  // cycle and restarts its step counter at zero.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      op_x_reg   <= '0;
      op_y_reg   <= '0;
      op_u_reg   <= 1'b0;
      pend_reg   <= 1'b0;
      res_lo_reg <= '0;
      res_hi_reg <= '0;
      full_reg   <= 1'b0;
      ready_reg  <= 1'b1;
      run_reg    <= 1'b0;
    end else if (flush) begin
      // Kill wins over a same-cycle capture: the product is dropped.
      state_reg <= IDLE;
      pend_reg  <= 1'b0;
      full_reg  <= 1'b0;
      ready_reg <= 1'b1;
      run_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_x_reg  <= req_x;
            op_y_reg  <= req_y;
            op_u_reg  <= req_u;
            state_reg <= RUN;
            run_reg   <= 1'b1;
            ready_reg <= 1'b0;
          end
        end

        RUN: begin
          if (capture) begin
            res_lo_reg <= mul_z[WORD_W-1:0];
            res_hi_reg <= mul_z[63:WORD_W];
            full_reg   <= 1'b1;
            run_reg    <= 1'b0;
            if (pend_reg) begin
              state_reg <= DONE_PEND;
              ready_reg <= 1'b0;
            end else begin
              state_reg <= DONE;
              ready_reg <= 1'b1;
            end
          end
        end

        DONE: begin
          if (accept && rsp_ready) begin
            // Result drains while the next run is issued straight away.
            op_x_reg  <= req_x;
            op_y_reg  <= req_y;
            op_u_reg  <= req_u;
            full_reg  <= 1'b0;
            state_reg <= RUN;
            run_reg   <= 1'b1;
            ready_reg <= 1'b0;
          end else if (accept) begin
            // Park the request; it cannot run until the result drains.
            op_x_reg  <= req_x;
            op_y_reg  <= req_y;
            op_u_reg  <= req_u;
            pend_reg  <= 1'b1;
            state_reg <= DONE_PEND;
            ready_reg <= 1'b0;
          end else if (rsp_ready) begin
            full_reg  <= 1'b0;
            state_reg <= IDLE;
            ready_reg <= 1'b1;
          end
        end

        DONE_PEND: begin
          if (rsp_ready) begin
            full_reg  <= 1'b0;
            pend_reg  <= 1'b0;
            state_reg <= RUN;
            run_reg   <= 1'b1;
            ready_reg <= 1'b0;
          end
        end

        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
          run_reg   <= 1'b0;
        end
      endcase
    end
  end

  // H register: follows the high word of every product that is kept.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      h_word_reg <= '0;
    end else if (capture && !flush) begin
      h_word_reg <= mul_z[63:WORD_W];
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer with a behavioural model of the
// iterative multiplier and a scoreboard of expected products.
module tb_mul_sequencer;
  import mul_pkg::*;

  logic        CLK = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_x = '0;
  logic [31:0] req_y = '0;
  logic        req_u = 1'b0;
  logic        mul_run;
  logic        mul_u;
  logic [31:0] mul_x;
  logic [31:0] mul_y;
  logic        mul_stall;
  logic [63:0] mul_z;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_lo;
  logic [31:0] rsp_hi;
  logic [31:0] h_reg;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] sb_q[$];

  mul_sequencer dut (
    .CLK       (CLK),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_u     (req_u),
    .mul_run   (mul_run),
    .mul_u     (mul_u),
    .mul_x     (mul_x),
    .mul_y     (mul_y),
    .mul_stall (mul_stall),
    .mul_z     (mul_z),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_lo    (rsp_lo),
    .rsp_hi    (rsp_hi),
    .h_reg     (h_reg)
  );

  always #5 CLK = ~CLK;

  // Reference product: u=1 is a signed multiply.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic u);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = u ? {{32{a[31]}}, a} : {32'd0, a};
    eb = u ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  // Multiplier model: step counter restarts whenever run is low; stall
  // falls in run cycle ITER, and only then is z a valid product.
  int s_cnt = 0;
  always @(posedge CLK) s_cnt <= mul_run ? s_cnt + 1 : 0;
  assign mul_stall = mul_run && (s_cnt != ITER - 1);
  assign mul_z = (mul_run && s_cnt == ITER - 1) ? ref_mul(mul_x, mul_y, mul_u)
                                                : 64'hDEADBEEF_BADC0FFE;

  always @(negedge CLK)
    if (mul_run && s_cnt >= ITER)
      $error("FAIL mul_stall_protocol: run cycle %0d exceeds %0d", s_cnt + 1, ITER);

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Offer one request and push its expected product on acceptance.
  // Returns just after the accepting edge (run cycle 1).
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic u);
    req_x = x; req_y = y; req_u = u; req_valid = 1'b1;
    checks++;
    for (int n = 0; n < 200; n++) begin
      @(negedge CLK);
      if (req_ready) begin
        sb_q.push_back(ref_mul(x, y, u));
        tick();
        req_valid = 1'b0;
        return;
      end
      tick();
    end
    errors++;
    $display("FAIL issue_timeout: req_ready=%b after 200 cycles, required 1", req_ready);
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for rsp_valid; cyc = run cycle in which it was seen,
  // or -1. Returns at the negedge of that cycle.
  task automatic wait_valid(output int cyc);
    for (int n = 0; n < 400; n++) begin
      @(negedge CLK);
      if (rsp_valid) begin
        cyc = n + 1;
        return;
      end
      tick();
    end
    cyc = -1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    @(negedge CLK);
    checks++;
    if (req_ready !== 1'b1 || mul_run !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready/run/valid=%b%b%b required 100", req_ready, mul_run, rsp_valid);
    end
    checks++;
    if (mul_x !== 0 || mul_y !== 0 || mul_u !== 0 || rsp_lo !== 0 || rsp_hi !== 0 || h_reg !== 0) begin
      errors++;
      $display("FAIL reset_data: x=%h y=%h u=%b lo=%h hi=%h h=%h required all 0",
               mul_x, mul_y, mul_u, rsp_lo, rsp_hi, h_reg);
    end
    tick();
    rst = 1'b1;
    tick();
    @(negedge CLK);
    checks++;
    if (req_ready !== 1'b1 || mul_run !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b run=%b required 1 0", req_ready, mul_run);
    end
    tick();
  endtask

  task automatic test_unsigned();
    int cyc;
    logic [63:0] exp;
    rsp_ready = 1'b1;
    issue(32'd3, 32'd5, 1'b0);
    wait_valid(cyc);
    checks++;
    if (cyc != ITER + 1) begin
      errors++;
      $display("FAIL latency: rsp_valid in cycle %0d, required %0d", cyc, ITER + 1);
    end
    checks++;
    if (rsp_lo !== 32'h0000000F || rsp_hi !== 32'h0 || h_reg !== 32'h0) begin
      errors++;
      $display("FAIL mul_3x5: lo=%h hi=%h h=%h required 0000000f 00000000 00000000", rsp_lo, rsp_hi, h_reg);
    end
    checks++;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    if ({rsp_hi, rsp_lo} !== exp) begin
      errors++;
      $display("FAIL sb_3x5: got %h required %h", {rsp_hi, rsp_lo}, exp);
    end
    tick();
    @(negedge CLK);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain_idle: valid=%b ready=%b required 0 1", rsp_valid, req_ready);
    end
    tick();
  endtask

  task automatic test_signed_ones();
    int cyc;
    logic [63:0] exp;
    rsp_ready = 1'b1;
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    wait_valid(cyc);
    checks++;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    if (cyc < 0 || rsp_lo !== 32'h1 || rsp_hi !== 32'h0 || {rsp_hi, rsp_lo} !== exp) begin
      errors++;
      $display("FAIL signed_m1: cyc=%0d lo=%h hi=%h required 00000001 00000000", cyc, rsp_lo, rsp_hi);
    end
    tick();
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    wait_valid(cyc);
    checks++;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    if (cyc < 0 || rsp_lo !== 32'h1 || rsp_hi !== 32'hFFFFFFFE || {rsp_hi, rsp_lo} !== exp) begin
      errors++;
      $display("FAIL unsigned_max: cyc=%0d lo=%h hi=%h required 00000001 fffffffe", cyc, rsp_lo, rsp_hi);
    end
    checks++;
    if (h_reg !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL h_unsigned_max: h=%h required fffffffe", h_reg);
    end
    tick();
  endtask

  task automatic test_operand_hold();
    int bad = 0;
    logic [63:0] exp;
    rsp_ready = 1'b1;
    issue(32'h80000000, 32'd2, 1'b1);
    for (int c = 1; c <= ITER; c++) begin
      @(negedge CLK);
      if (mul_run !== 1'b1 || mul_x !== 32'h80000000 || mul_y !== 32'd2 || mul_u !== 1'b1) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL operand_hold: %0d run cycles with wrong run/x/y/u, required 0", bad);
    end
    @(negedge CLK);
    checks++;
    if (rsp_valid !== 1'b1 || mul_run !== 1'b0) begin
      errors++;
      $display("FAIL run_end: valid=%b run=%b in cycle %0d, required 1 0", rsp_valid, mul_run, ITER + 1);
    end
    checks++;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    if (rsp_lo !== 32'h0 || rsp_hi !== 32'hFFFFFFFF || h_reg !== 32'hFFFFFFFF || {rsp_hi, rsp_lo} !== exp) begin
      errors++;
      $display("FAIL signed_min_x2: lo=%h hi=%h h=%h required 00000000 ffffffff ffffffff", rsp_lo, rsp_hi, h_reg);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] tx[3] = '{32'h00001234, 32'hFFFF0001, 32'h7FFFFFFF};
    logic [31:0] ty[3] = '{32'h00005678, 32'h00010001, 32'h80000000};
    logic        tu[3] = '{1'b0, 1'b1, 1'b1};
    int idx = 0, got = 0, prev = -1, run_len = 0, long_runs = 0, gaps_bad = 0;
    logic acc;
    logic [63:0] exp;
    rsp_ready = 1'b1;
    req_x = tx[0]; req_y = ty[0]; req_u = tu[0]; req_valid = 1'b1;
    for (int c = 0; c < 300 && got < 3; c++) begin
      @(negedge CLK);
      acc = req_valid && req_ready;
      if (acc) sb_q.push_back(ref_mul(tx[idx], ty[idx], tu[idx]));
      if (mul_run) run_len++; else run_len = 0;
      if (run_len > ITER) long_runs++;
      if (rsp_valid) begin
        checks++;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
        if ({rsp_hi, rsp_lo} !== exp) begin
          errors++;
          $display("FAIL b2b_result%0d: got %h required %h", got, {rsp_hi, rsp_lo}, exp);
        end
        if (prev >= 0 && c - prev != ITER + 1) gaps_bad++;
        prev = c;
        got++;
      end
      tick();
      if (acc) begin
        idx++;
        if (idx < 3) begin
          req_x = tx[idx]; req_y = ty[idx]; req_u = tu[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    checks++;
    if (got != 3 || gaps_bad != 0) begin
      errors++;
      $display("FAIL b2b_throughput: products=%0d bad_spacing=%0d required 3 0 (period %0d)", got, gaps_bad, ITER + 1);
    end
    checks++;
    if (long_runs != 0) begin
      errors++;
      $display("FAIL run_gap: run held over %0d cycles %0d times, required 0", ITER, long_runs);
    end
  endtask

  task automatic test_backpressure();
    int cyc, accepts = 0, run_bad = 0, unstable = 0;
    logic [63:0] exp_a;
    logic [63:0] exp;
    rsp_ready = 1'b0;
    issue(32'h12345678, 32'h9ABCDEF0, 1'b0);
    exp_a = ref_mul(32'h12345678, 32'h9ABCDEF0, 1'b0);
    wait_valid(cyc);
    tick();
    req_x = 32'h00000100; req_y = 32'h00000100; req_u = 1'b0; req_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge CLK);
      if (req_valid && req_ready) begin
        accepts++;
        sb_q.push_back(ref_mul(32'h00000100, 32'h00000100, 1'b0));
      end
      if (mul_run !== 1'b0) run_bad++;
      if (rsp_valid !== 1'b1 || {rsp_hi, rsp_lo} !== exp_a) unstable++;
      tick();
    end
    req_valid = 1'b0;
    checks++;
    if (cyc < 0 || accepts != 1) begin
      errors++;
      $display("FAIL bp_accepts: first_valid=%0d accepts=%0d required 1 accept", cyc, accepts);
    end
    checks++;
    if (run_bad != 0 || unstable != 0) begin
      errors++;
      $display("FAIL bp_hold: run_high=%0d unstable=%0d required 0 0", run_bad, unstable);
    end
    checks++;
    if (dut.state_reg !== DONE_PEND) begin
      errors++;
      $display("FAIL bp_state: state=%0d required %0d", dut.state_reg, DONE_PEND);
    end
    rsp_ready = 1'b1;
    @(negedge CLK);
    checks++;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    if (rsp_valid !== 1'b1 || {rsp_hi, rsp_lo} !== exp) begin
      errors++;
      $display("FAIL bp_first: valid=%b got %h required %h", rsp_valid, {rsp_hi, rsp_lo}, exp);
    end
    tick();
    @(negedge CLK);
    checks++;
    if (mul_run !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_restart: run=%b valid=%b required 1 0", mul_run, rsp_valid);
    end
    tick();
    wait_valid(cyc);
    checks++;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    if (cyc < 0 || {rsp_hi, rsp_lo} !== exp || rsp_lo !== 32'h00010000) begin
      errors++;
      $display("FAIL bp_second: got %h required %h", {rsp_hi, rsp_lo}, exp);
    end
    tick();
  endtask

  task automatic test_flush();
    int cyc, bad;
    logic [31:0] h_before;
    logic [63:0] exp;
    rsp_ready = 1'b1;
    h_before = h_reg;
    // Flush in run cycle 10, then in the capture cycle (flush must win).
    for (int k = 0; k < 2; k++) begin
      issue(32'hFFFFFFFF, 32'd7, 1'b0);
      for (int c = 1; c < (k == 0 ? 10 : ITER); c++) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      if (sb_q.size() > 0) void'(sb_q.pop_back());
      @(negedge CLK);
      checks++;
      if (mul_run !== 1'b0 || req_ready !== 1'b1 || dut.state_reg !== IDLE) begin
        errors++;
        $display("FAIL flush%0d_idle: run=%b ready=%b state=%0d required 0 1 %0d",
                 k, mul_run, req_ready, dut.state_reg, IDLE);
      end
      bad = 0;
      for (int c = 0; c < 40; c++) begin
        tick();
        @(negedge CLK);
        if (rsp_valid !== 1'b0 || h_reg !== h_before) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL flush%0d_discard: %0d cycles with valid or h changed (h=%h), required 0 (h=%h)",
                 k, bad, h_reg, h_before);
      end
      tick();
    end
    issue(32'hFFFFFFFE, 32'd3, 1'b1);
    wait_valid(cyc);
    checks++;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    if (cyc < 0 || rsp_lo !== 32'hFFFFFFFA || rsp_hi !== 32'hFFFFFFFF || h_reg !== 32'hFFFFFFFF
        || {rsp_hi, rsp_lo} !== exp) begin
      errors++;
      $display("FAIL post_flush: lo=%h hi=%h h=%h required fffffffa ffffffff ffffffff", rsp_lo, rsp_hi, h_reg);
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    int cyc;
    logic [63:0] exp;
    rsp_ready = 1'b1;
    issue(32'h00001000, 32'h00001000, 1'b0);
    for (int c = 1; c < 20; c++) tick();
    rst = 1'b0;
    #1;
    if (sb_q.size() > 0) void'(sb_q.pop_back());
    checks++;
    if (req_ready !== 1'b1 || mul_run !== 1'b0 || rsp_valid !== 1'b0 || mul_x !== 0 || mul_y !== 0
        || mul_u !== 0 || rsp_lo !== 0 || rsp_hi !== 0 || h_reg !== 0) begin
      errors++;
      $display("FAIL midrun_reset: ready=%b run=%b valid=%b x=%h y=%h lo=%h hi=%h h=%h required reset values",
               req_ready, mul_run, rsp_valid, mul_x, mul_y, rsp_lo, rsp_hi, h_reg);
    end
    tick(); tick();
    rst = 1'b1;
    tick();
    issue(32'd7, 32'd6, 1'b0);
    wait_valid(cyc);
    checks++;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    if (cyc != ITER + 1 || rsp_lo !== 32'd42 || rsp_hi !== 32'd0 || {rsp_hi, rsp_lo} !== exp) begin
      errors++;
      $display("FAIL after_reset_7x6: cyc=%0d lo=%0d hi=%h required cyc %0d lo 42 hi 0", cyc, rsp_lo, rsp_hi, ITER + 1);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed_ones();
    test_operand_hold();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_midrun();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d products never returned, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Issue/retire sequencer that sits directly in front of the iterative 32-cycle multiplier and drives its run/stall protocol. It accepts multiply requests over a valid/ready handshake, holds the operands stable for the full iteration, captures the 64-bit product, and presents it over a valid/ready response channel. It also maintains the architectural H register (high product word). The multiplier itself is instantiated beside this block in the parent, not inside it.

## Interface
- ITER, 32, multiplier iteration count; `mul_stall` must fall in cycle ITER of a run.
- CLK  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all in-flight work; H is preserved.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when `req_valid & req_ready`.
- req_x, req_y  in  32  operands.
- req_u  in  1  1 = signed multiply, 0 = unsigned.
- mul_run  out  1  to multiplier `run`.
- mul_u  out  1  to multiplier `u`.
- mul_x, mul_y  out  32  to multiplier `x`, `y`.
- mul_stall  in  1  from multiplier `stall`.
- mul_z  in  64  from multiplier `z`.
- rsp_valid  out  1  product available.
- rsp_ready  in  1  consumer takes the product.
- rsp_lo, rsp_hi  out  32  product low and high words.
- h_reg  out  32  H register; last captured `rsp_hi`.

## Operation
- States: IDLE, RUN, DONE, DONE_PEND.
- Operand register: x, y, u plus a pending flag. Result register: lo, hi plus a full flag.
- IDLE: `req_ready`=1. On accept, load the operand register and go to RUN.
- RUN: `mul_run`=1; `mul_x/y/u` come from the operand register and are held constant. `req_ready`=0.
  - When `mul_stall`=0, capture `mul_z` into the result register and copy `mul_z[63:32]` into `h_reg`.
  - Then go to DONE, or to DONE_PEND if a request is pending.
- DONE: `rsp_valid`=1, `mul_run`=0, `req_ready`=1.
  - Accept only: load the operands; go to DONE_PEND.
  - `rsp_ready` only: go to IDLE.
  - Both in the same cycle: go to RUN directly with the new operands.
- DONE_PEND: `rsp_valid`=1, `req_ready`=0, `mul_run`=0. On `rsp_ready`, go to RUN.
- A new run never starts while the result register is full and not draining, because the multiplier cannot be held at completion.
- `mul_run` is low for at least one cycle between runs, so the multiplier's state counter restarts at 0.
- flush: go to IDLE, clear the pending and full flags, drive `mul_run`=0 in the next cycle. An in-flight product is discarded and H is not written. If flush and `mul_stall`=0 occur in the same cycle, flush wins.
- Sign handling is done entirely by the multiplier; `req_u` is passed through unchanged.

## Timing
- Reset values: state IDLE; `req_ready`=1; `mul_run`=0; `rsp_valid`=0; `mul_x/y`, `mul_u`, `rsp_lo/hi`, `h_reg` all 0.
- Latency: accept in cycle 0 → `mul_run` high in cycles 1..ITER → `mul_stall`=0 in cycle ITER → `rsp_valid` from cycle ITER+1.
- Back-to-back throughput with `rsp_ready` tied high: one product every ITER+1 cycles (the run gap).
- `rsp_lo/hi` are stable while `rsp_valid`=1 and `rsp_ready`=0.
- `h_reg` changes only in the cycle after a capture.
- If `mul_stall` is still 1 after ITER cycles of run, that is a protocol violation. A bench assertion flags it; the RTL keeps waiting.
- Reset mid-run: all outputs go to their reset values immediately.

## Structure
- Shared package `mul_pkg`: state enum `mul_state_t`, the `ITER` default, word width 32.
- Single flat module; no sub-module is natural. The result register and operand register are plain flops.
- The parent wires `mul_*` to `Multiplier`.

## Test plan
- Unsigned 3×5, `rsp_ready`=1 → `rsp_valid` in cycle 33; lo=0x0000000F, hi=0, `h_reg`=0.
- Signed 0xFFFFFFFF×0xFFFFFFFF → lo=1, hi=0. Unsigned same operands → lo=1, hi=0xFFFFFFFE, `h_reg`=0xFFFFFFFE.
- Signed 0x80000000×2 → lo=0, hi=0xFFFFFFFF. `mul_x/y` stay constant for all 32 run cycles; `mul_run` has a gap of at least 1 cycle before the next run.
- Backpressure: hold `rsp_ready`=0 for 50 cycles and offer a second request.
  - Required: second request accepted once; state DONE_PEND; `mul_run`=0 throughout; first product stable.
  - On `rsp_ready`: second run starts in the next cycle, and the second result is correct.
- Flush in cycle 10 of a run → IDLE; no `rsp_valid`; `h_reg` unchanged; `mul_run`=0 in the following cycle; next request yields a correct product.
- Assert `rst` low in cycle 20 of a run → outputs at reset values; after release, 7×6 unsigned → lo=42.
